// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the serial datapath blocks.
// Contents:
//   subState_e - control states of the bit-serial arithmetic units
//   CNT_W      - width of a bit counter that must reach n-1
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } subState_e;

  // A counter that only ever has to reach n-1 needs $clog2(n) bits, but
  // never fewer than one so that single-bit operands still get a counter.
  function automatic int CNT_W(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor computing x - y - bin.
// Ports:
//   x    - minuend bit
//   y    - subtrahend bit
//   bin  - borrow in from the less significant position
//   d    - difference bit
//   bout - borrow out to the more significant position
// Kept as its own module so a parallel ripple subtractor can reuse it.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // A borrow leaves this position when y exceeds x outright, or when
  // the bits are equal and a borrow was already coming in.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/gen_serial_sub.sv
// Bit-serial subtractor producing the exact N+1-bit difference a - b,
// one bit per clock, LSB first, through a single borrow flip-flop.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - begin a subtraction (only looked at while idle)
//   a, b  - N-bit minuend / subtrahend, captured on the accepted start
//   busy  - high while the operation runs and during the done cycle
//   done  - one-cycle pulse, diff is valid in the same cycle
//   diff  - {borrow_out, (a-b) mod 2^N}, held until the next done
module gen_serial_sub
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N:0]   diff
);

  localparam int CntW = CNT_W(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  subState_e       state_q, state_d;
  logic [N-1:0]    aSh_q, aSh_d;
  logic [N-1:0]    bSh_q, bSh_d;
  logic [N-1:0]    result_q, result_d;
  logic            borrow_q, borrow_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N:0]      diff_q, diff_d;

  logic cellD;
  logic cellBout;

  // The single subtractor cell always looks at the current LSBs of the
  // shift registers together with the stored borrow.
  full_sub_cell uCell (
    .x   (aSh_q[0]),
    .y   (bSh_q[0]),
    .bin (borrow_q),
    .d   (cellD),
    .bout(cellBout)
  );

  // Next-state and output logic. Every register holds by default; the
  // result register shifts right so that after N steps the first (LSB)
  // difference bit has reached bit 0. The final difference is loaded
  // into diff on the last RUN step so it is already stable in DONE.
  always_comb begin
    state_d  = state_q;
    aSh_d    = aSh_q;
    bSh_d    = bSh_q;
    result_d = result_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          aSh_d    = a;
          bSh_d    = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        busy              = 1'b1;
        borrow_d          = cellBout;
        aSh_d             = aSh_q >> 1;
        bSh_d             = bSh_q >> 1;
        result_d          = result_q >> 1;
        result_d[N-1]     = cellD;
        cnt_d             = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          diff_d  = {cellBout, result_d};
          state_d = DONE;
        end
      end

      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset clears everything, including a result that
  // was still in flight, so an aborted operation never reports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      aSh_q    <= '0;
      bSh_q    <= '0;
      result_q <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
    end else begin
      state_q  <= state_d;
      aSh_q    <= aSh_d;
      bSh_q    <= bSh_d;
      result_q <= result_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
    end
  end

  assign diff = diff_q;

endmodule

// File: tb/tb_gen_serial_sub.sv
// Self-checking bench for gen_serial_sub at N=4, N=1 and N=8.
// A transaction-level model predicts busy/done/diff for each instance
// and is compared every cycle; directed operations also check literal
// results and the accept-to-done latency.
module tb_gen_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       startV[3];
  logic [7:0] aV[3];
  logic [7:0] bV[3];
  logic       busyV[3];
  logic       doneV[3];
  logic [4:0] diff4;
  logic [1:0] diff1;
  logic [8:0] diff8;
  logic [8:0] diffV[3];

  int widthN[3] = '{4, 1, 8};

  int checks = 0;
  int passes = 0;
  bit checkEn = 1'b0;

  gen_serial_sub #(.N(4)) uDut4 (
    .clk  (clk),
    .rst  (rst),
    .start(startV[0]),
    .a    (aV[0][3:0]),
    .b    (bV[0][3:0]),
    .busy (busyV[0]),
    .done (doneV[0]),
    .diff (diff4)
  );

  gen_serial_sub #(.N(1)) uDut1 (
    .clk  (clk),
    .rst  (rst),
    .start(startV[1]),
    .a    (aV[1][0:0]),
    .b    (bV[1][0:0]),
    .busy (busyV[1]),
    .done (doneV[1]),
    .diff (diff1)
  );

  gen_serial_sub #(.N(8)) uDut8 (
    .clk  (clk),
    .rst  (rst),
    .start(startV[2]),
    .a    (aV[2]),
    .b    (bV[2]),
    .busy (busyV[2]),
    .done (doneV[2]),
    .diff (diff8)
  );

  assign diffV[0] = {4'b0, diff4};
  assign diffV[1] = {7'b0, diff1};
  assign diffV[2] = diff8;

  // Transaction model: an accepted operation keeps the unit busy for
  // N+1 cycles, the last of which is the done cycle, and the result is
  // simply the integer difference truncated to N+1 bits.
  int         left[3]    = '{0, 0, 0};
  logic [8:0] expPend[3] = '{9'd0, 9'd0, 9'd0};
  logic [8:0] expHeld[3] = '{9'd0, 9'd0, 9'd0};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int n;
      int av;
      int bv;
      n  = widthN[i];
      av = int'(aV[i]) & ((1 << n) - 1);
      bv = int'(bV[i]) & ((1 << n) - 1);
      if (rst) begin
        left[i]    <= 0;
        expHeld[i] <= '0;
      end else if (left[i] == 0) begin
        if (startV[i]) begin
          expPend[i] <= 9'((av - bv) & ((1 << (n + 1)) - 1));
          left[i]    <= n + 1;
        end
      end else begin
        left[i] <= left[i] - 1;
        if (left[i] == 2) expHeld[i] <= expPend[i];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("model_busy%0d", i), 32'(busyV[i]), 32'(left[i] > 0));
        checkOutput($sformatf("model_done%0d", i), 32'(doneV[i]), 32'(left[i] == 1));
        checkOutput($sformatf("model_diff%0d", i), 32'(diffV[i]), 32'(expHeld[i]));
      end
    end
  end

  // Runs one operation from an idle unit, then checks the diff in the
  // done cycle, the number of cycles from the accept cycle to done, and
  // how many cycles busy was high. Starts and ends just after posedge.
  task automatic applyStimulus(input int idx, input logic [7:0] av,
                               input logic [7:0] bv, input logic [8:0] expDiff,
                               input int expLat, input string name);
    int lat;
    int busyCnt;
    lat     = -1;
    busyCnt = 0;
    aV[idx]     = av;
    bV[idx]     = bv;
    startV[idx] = 1'b1;
    @(posedge clk);
    #1 startV[idx] = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (busyV[idx]) busyCnt++;
      if (doneV[idx]) begin
        lat = k;
        checkOutput({name, "_diff"}, 32'(diffV[idx]), 32'(expDiff));
      end
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, "_busyCycles"}, 32'(busyCnt), 32'(expLat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int         dones;
    int         found;
    logic [8:0] gotDiff;
    logic [7:0] ra;
    logic [7:0] rb;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      startV[i] = 1'b0;
      aV[i]     = '0;
      bV[i]     = '0;
    end
    @(posedge clk);
    #1 checkEn = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: nothing moves.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("idle_busy", 32'(busyV[0]), 32'd0);
      checkOutput("idle_done", 32'(doneV[0]), 32'd0);
      checkOutput("idle_diff", 32'(diffV[0]), 32'd0);
    end
    @(posedge clk);
    #1;

    // N=4 directed values, results written out by hand.
    applyStimulus(0, 8'd9,  8'd3,  9'b0_0011_0, 5, "a9b3");
    applyStimulus(0, 8'd3,  8'd5,  9'b0_1111_0, 5, "a3b5");
    applyStimulus(0, 8'd0,  8'd15, 9'b0_1000_1, 5, "a0b15");
    applyStimulus(0, 8'd15, 8'd0,  9'b0_0111_1, 5, "a15b0");

    // start held high through a whole operation, operands disturbed
    // during RUN; the op after DONE is accepted one idle cycle later.
    aV[0] = 8'd7;
    bV[0] = 8'd2;
    startV[0] = 1'b1;
    @(posedge clk);
    #1 aV[0] = 8'd15;
    bV[0] = 8'd15;
    dones   = 0;
    gotDiff = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (doneV[0]) begin
        dones++;
        gotDiff = diffV[0];
      end
    end
    checkOutput("heldStart_dones", 32'(dones), 32'd1);
    checkOutput("heldStart_diff", 32'(gotDiff), 32'd5);
    @(negedge clk);
    checkOutput("heldStart_gapIdle", 32'(busyV[0]), 32'd0);
    @(posedge clk);
    #1 startV[0] = 1'b0;
    @(negedge clk);
    checkOutput("heldStart_reaccept", 32'(busyV[0]), 32'd1);
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge clk);
      if (doneV[0]) begin
        found = 1;
        checkOutput("heldStart_secondDiff", 32'(diffV[0]), 32'd0);
      end
    end
    checkOutput("heldStart_secondDone", 32'(found), 32'd1);
    @(posedge clk);
    #1;

    // Reset during the second RUN cycle aborts the operation.
    aV[0] = 8'd12;
    bV[0] = 8'd4;
    startV[0] = 1'b1;
    @(posedge clk);
    #1 startV[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (doneV[0]) dones++;
    end
    checkOutput("abort_dones", 32'(dones), 32'd0);
    checkOutput("abort_diff", 32'(diffV[0]), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(0, 8'd8, 8'd8, 9'd0, 5, "a8b8");

    // N=1: a single RUN cycle.
    applyStimulus(1, 8'd0, 8'd1, 9'b11, 2, "n1_a0b1");
    applyStimulus(1, 8'd1, 8'd0, 9'b01, 2, "n1_a1b0");
    applyStimulus(1, 8'd1, 8'd1, 9'b00, 2, "n1_a1b1");

    // N=8 extremes, then random operations.
    applyStimulus(2, 8'd0,   8'd255, 9'h101, 9, "n8_a0b255");
    applyStimulus(2, 8'd255, 8'd0,   9'h0FF, 9, "n8_a255b0");
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(2, ra, rb, {1'b0, ra} - {1'b0, rb}, 9, "n8_rand");
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
